deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, giving the assembled word width; the integration value is 16, matching the downstream buffer data_1.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the pushed-word counter.
REQ-003 The block SHALL have port clk_1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port data_in, input, 1 bit: serial data bit, MSB first.
REQ-006 The block SHALL have port write_in, input, 1 bit: data_in is valid this cycle.
REQ-007 The block SHALL have port buffer_full, input, 1 bit: the downstream buffer cannot accept a word.
REQ-008 The block SHALL have port data_1, output, WORD_W bits: the assembled word.
REQ-009 The block SHALL have port data_1_en, output, 1 bit: data_1 is valid and is written downstream this cycle.
REQ-010 The block SHALL have port status_out, output, 1 bit: the block accepts serial bits this cycle.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky flag; a bit arrived while status_out was low.
REQ-012 The block SHALL have port word_count, output, CNT_W bits: number of words pushed, modulo 2^CNT_W.

Function
REQ-013 The FSM SHALL have exactly two states, RX (accepting bits) and PUSH (complete word held).
REQ-014 status_out SHALL be 1 exactly when the state is RX, decoded from registered state only.
REQ-015 A bit SHALL be accepted on a rising edge where status_out=1 and write_in=1: shift register <= {shreg[WORD_W-2:0], data_in}, and the bit counter increments.
REQ-016 Cycles with write_in=0 SHALL leave the shift register and the bit counter unchanged; gaps of any length are legal.
REQ-017 On acceptance of bit number WORD_W (bit counter = WORD_W-1), the full word SHALL be loaded into the data_1 register, the bit counter SHALL return to 0, and the state SHALL go to PUSH, all on the same edge.
REQ-018 data_1_en SHALL equal (state==PUSH) AND NOT buffer_full, combinationally, so it is never high while buffer_full=1.
REQ-019 In PUSH with buffer_full=0, the state SHALL return to RX on the next edge and word_count SHALL increment by 1.
REQ-020 In PUSH with buffer_full=1, the block SHALL hold the state, data_1 and word_count indefinitely.
REQ-021 Latency: data_1_en SHALL be high in the first cycle after the edge accepting the last bit, provided buffer_full=0; each word SHALL produce exactly one data_1_en cycle.
REQ-022 data_1 SHALL be stable from entry into PUSH until at least the edge that leaves PUSH.
REQ-023 write_in=1 while status_out=0 SHALL discard the bit and set ovf to 1 on that edge; ovf SHALL clear only on reset.
REQ-024 word_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-025 The block SHALL not accept a bit in the cycle it leaves PUSH; acceptance resumes in the following cycle, in RX.

Reset
REQ-026 On a rising clk_1 edge with rst=1, state SHALL be RX, the bit counter 0, the shift register 0, data_1 0, ovf 0 and word_count 0; data_1_en is then 0 and status_out 1 in the next cycle.
REQ-027 Reset mid-word or in PUSH SHALL discard the partial or held word with no data_1_en pulse, and rst SHALL take priority over all other inputs.

Structure
REQ-028 A shared package SHALL hold the state encoding (RX, PUSH) and the default WORD_W and CNT_W constants.
REQ-029 The shift register and bit counter SHALL be one sub-module, deser_shreg, with outputs word and last_bit; the FSM, ovf and word_count SHALL stay in deserializer.

Verification
REQ-030 The bench SHALL shift 16'hA5C3 MSB-first with buffer_full=0 -> data_1_en high for exactly one cycle, in the first cycle after bit 16, with data_1=16'hA5C3 and word_count=1.
REQ-031 The bench SHALL drive buffer_full=1 before bit 16 of 16'h1234 and release it 5 cycles later -> data_1_en stays 0 and status_out 0 for 5 cycles, then one data_1_en cycle with data_1=16'h1234.
REQ-032 The bench SHALL hold write_in=1 throughout the PUSH cycle of the last test -> ovf=1 and stays 1; the next word, 16'hFFFF, still assembles correctly.
REQ-033 The bench SHALL assert rst for one cycle after 7 bits, then send 16'h8001 -> exactly one data_1_en, with data_1=16'h8001 and word_count=1.
REQ-034 The bench SHALL send 16'h0F0F with random idle gaps of 0-3 cycles between bits -> data_1=16'h0F0F and a single data_1_en.
REQ-035 The bench SHALL push 256 words -> word_count returns to 0 and ovf stays 0.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial-to-parallel word assembler.
// Holds the FSM encoding and the default word and counter widths.
package deserializer_pkg;

    localparam int DEFAULT_WORD_W = 16;
    localparam int DEFAULT_CNT_W  = 8;

    typedef enum logic {
        ST_RX   = 1'b0,
        ST_PUSH = 1'b1
    } state_t;

endpackage : deserializer_pkg

// File: rtl/deser_shreg.sv
// Serial shift register and bit counter for the deserializer.
// word is the complete word as it would look with the current data_in shifted in.
module deser_shreg
    import deserializer_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              data_in,
    output logic [WORD_W-1:0] word,
    output logic              last_bit
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WORD_W - 1);

    // Only the older WORD_W-1 bits need storage; the newest bit is data_in itself.
    logic [WORD_W-2:0] shreg_r;
    logic [BIT_W-1:0]  bit_cnt_r;

    assign word     = {shreg_r, data_in};
    assign last_bit = (bit_cnt_r == LAST_IDX);

    // Shift in accepted bits and count position within the word.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            shreg_r   <= {(WORD_W-1){1'b0}};
            bit_cnt_r <= BIT_W'(0);
        end else if (shift_en) begin
            shreg_r <= word[WORD_W-2:0];
            if (last_bit) begin
                bit_cnt_r <= BIT_W'(0);
            end else begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
        end else begin
            shreg_r   <= shreg_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

endmodule : deser_shreg

// File: rtl/deserializer.sv
// MSB-first serial deserializer with a two-state RX/PUSH handshake.
// Holds a completed word while the downstream buffer is full.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              buffer_full,
    output logic [WORD_W-1:0] data_1,
    output logic              data_1_en,
    output logic              status_out,
    output logic              ovf,
    output logic [CNT_W-1:0]  word_count
);

    state_t            state_r;
    logic [WORD_W-1:0] data_1_r;
    logic              ovf_r;
    logic [CNT_W-1:0]  word_count_r;

    logic              accept_s;
    logic [WORD_W-1:0] word_s;
    logic              last_bit_s;

    assign status_out = (state_r == ST_RX);
    assign accept_s   = status_out & write_in;
    assign data_1_en  = (state_r == ST_PUSH) & ~buffer_full;
    assign data_1     = data_1_r;
    assign ovf        = ovf_r;
    assign word_count = word_count_r;

    deser_shreg #(
        .WORD_W (WORD_W)
    ) u_shreg (
        .clk_1    (clk_1),
        .rst      (rst),
        .shift_en (accept_s),
        .data_in  (data_in),
        .word     (word_s),
        .last_bit (last_bit_s)
    );

    // Handshake FSM with output word, overflow flag and pushed-word counter.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_r      <= ST_RX;
            data_1_r     <= {WORD_W{1'b0}};
            ovf_r        <= 1'b0;
            word_count_r <= {CNT_W{1'b0}};
        end else begin
            // A bit offered while not accepting is lost; remember that until reset.
            if (write_in && !status_out) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end

            case (state_r)
                ST_RX: begin
                    if (accept_s && last_bit_s) begin
                        data_1_r <= word_s;
                        state_r  <= ST_PUSH;
                    end else begin
                        data_1_r <= data_1_r;
                        state_r  <= ST_RX;
                    end
                    word_count_r <= word_count_r;
                end
                ST_PUSH: begin
                    data_1_r <= data_1_r;
                    if (!buffer_full) begin
                        state_r      <= ST_RX;
                        word_count_r <= word_count_r + CNT_W'(1);
                    end else begin
                        state_r      <= ST_PUSH;
                        word_count_r <= word_count_r;
                    end
                end
                default: begin
                    state_r      <= ST_RX;
                    data_1_r     <= data_1_r;
                    word_count_r <= word_count_r;
                end
            endcase
        end
    end

endmodule : deserializer

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus random words
// compared against a bit-accumulating reference model and a pulse monitor.
module tb_deserializer;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b1;
    logic        data_in = 1'b0;
    logic        write_in = 1'b0;
    logic        buffer_full = 1'b0;
    logic [15:0] data_1;
    logic        data_1_en;
    logic        status_out;
    logic        ovf;
    logic [7:0]  word_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model: accumulated value and bit count of the word in flight.
    int          m_val = 0;
    int          m_cnt = 0;
    logic [15:0] exp_q[$];

    deserializer #(.WORD_W(16), .CNT_W(8)) dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .data_in     (data_in),
        .write_in    (write_in),
        .buffer_full (buffer_full),
        .data_1      (data_1),
        .data_1_en   (data_1_en),
        .status_out  (status_out),
        .ovf         (ovf),
        .word_count  (word_count)
    );

    always #5 clk_1 = ~clk_1;

    // Every data_1_en cycle must deliver the oldest word the model completed.
    always @(negedge clk_1) begin
        if (data_1_en === 1'b1) begin
            logic [15:0] exp_w;
            pulses = pulses + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse: data_1_en=1 data_1=%h with no word expected", data_1);
            end else begin
                exp_w = exp_q.pop_front();
                if (data_1 !== exp_w) begin
                    errors = errors + 1;
                    $display("FAIL pushed_word: got %h expected %h", data_1, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic wait_rx();
        int n = 0;
        while (status_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (status_out !== 1'b1) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL wait_rx: status_out stuck at %b after %0d cycles", status_out, n);
        end
    endtask

    // Send the top nbits of w, MSB first, with random idle gaps up to gap_max.
    task automatic send_bits(input logic [15:0] w, input int nbits, input int gap_max);
        for (int i = 15; i > 15 - nbits; i--) begin
            int gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int g = 0; g < gap; g++) begin
                write_in = 1'b0;
                data_in  = 1'($urandom);
                tick();
            end
            wait_rx();
            write_in = 1'b1;
            data_in  = w[i];
            tick();
            write_in = 1'b0;
            m_val = m_val * 2 + (w[i] ? 1 : 0);
            m_cnt = m_cnt + 1;
            if (m_cnt == 16) begin
                exp_q.push_back(16'(m_val % 65536));
                m_val = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        write_in = 1'b0;
        tick();
        rst   = 1'b0;
        m_val = 0;
        m_cnt = 0;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL missing_pulse: %0d word(s) never delivered before reset", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks = checks + 1;
        if (status_out !== 1'b1 || data_1_en !== 1'b0 || ovf !== 1'b0 ||
            word_count !== 8'd0 || data_1 !== 16'h0000) begin
            errors = errors + 1;
            $display("FAIL reset_state: status=%b en=%b ovf=%b cnt=%0d data=%h expected 1 0 0 0 0000",
                     status_out, data_1_en, ovf, word_count, data_1);
        end
    endtask

    task automatic test_basic();
        int p0 = pulses;
        send_bits(16'hA5C3, 16, 0);
        #1;
        checks = checks + 1;
        if (data_1_en !== 1'b1 || data_1 !== 16'hA5C3 || status_out !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL basic_latency: en=%b data=%h status=%b expected 1 a5c3 0",
                     data_1_en, data_1, status_out);
        end
        tick();
        checks = checks + 1;
        if (data_1_en !== 1'b0 || status_out !== 1'b1 || word_count !== 8'd1) begin
            errors = errors + 1;
            $display("FAIL basic_after: en=%b status=%b cnt=%0d expected 0 1 1",
                     data_1_en, status_out, word_count);
        end
        tick();
        tick();
        checks = checks + 1;
        if (pulses - p0 != 1) begin
            errors = errors + 1;
            $display("FAIL basic_pulses: got %0d expected 1", pulses - p0);
        end
    endtask

    task automatic test_backpressure_ovf();
        int p0 = pulses;
        send_bits(16'h1234, 15, 0);
        buffer_full = 1'b1;
        send_bits(16'h1234 << 15, 1, 0);
        // Offer bits throughout the held PUSH period; each must be discarded.
        for (int c = 0; c < 5; c++) begin
            write_in = 1'b1;
            data_in  = 1'($urandom);
            #1;
            checks = checks + 1;
            if (data_1_en !== 1'b0 || status_out !== 1'b0 || data_1 !== 16'h1234) begin
                errors = errors + 1;
                $display("FAIL hold_cycle%0d: en=%b status=%b data=%h expected 0 0 1234",
                         c, data_1_en, status_out, data_1);
            end
            tick();
        end
        buffer_full = 1'b0;
        write_in    = 1'b1;
        #1;
        checks = checks + 1;
        if (data_1_en !== 1'b1 || data_1 !== 16'h1234 || word_count !== 8'd1) begin
            errors = errors + 1;
            $display("FAIL release: en=%b data=%h cnt=%0d expected 1 1234 1",
                     data_1_en, data_1, word_count);
        end
        tick();
        write_in = 1'b0;
        checks = checks + 1;
        if (ovf !== 1'b1 || word_count !== 8'd2 || status_out !== 1'b1 || pulses - p0 != 1) begin
            errors = errors + 1;
            $display("FAIL after_release: ovf=%b cnt=%0d status=%b pulses=%0d expected 1 2 1 1",
                     ovf, word_count, status_out, pulses - p0);
        end
        send_bits(16'hFFFF, 16, 0);
        tick();
        tick();
        checks = checks + 1;
        if (ovf !== 1'b1 || word_count !== 8'd3 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL ffff_word: ovf=%b cnt=%0d pending=%0d expected 1 3 0",
                     ovf, word_count, exp_q.size());
        end
    endtask

    task automatic test_reset_midword();
        int p0;
        send_bits(16'hFE00, 7, 0);
        apply_reset();
        checks = checks + 1;
        if (ovf !== 1'b0 || word_count !== 8'd0 || status_out !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL midword_reset: ovf=%b cnt=%0d status=%b expected 0 0 1",
                     ovf, word_count, status_out);
        end
        p0 = pulses;
        send_bits(16'h8001, 16, 0);
        tick();
        tick();
        checks = checks + 1;
        if (pulses - p0 != 1 || word_count !== 8'd1 || data_1 !== 16'h8001) begin
            errors = errors + 1;
            $display("FAIL word_8001: pulses=%0d cnt=%0d data=%h expected 1 1 8001",
                     pulses - p0, word_count, data_1);
        end
    endtask

    task automatic test_gaps();
        int p0 = pulses;
        send_bits(16'h0F0F, 16, 3);
        for (int c = 0; c < 4; c++) tick();
        checks = checks + 1;
        if (pulses - p0 != 1 || data_1 !== 16'h0F0F || word_count !== 8'd2) begin
            errors = errors + 1;
            $display("FAIL gap_word: pulses=%0d data=%h cnt=%0d expected 1 0f0f 2",
                     pulses - p0, data_1, word_count);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 256; k++) begin
            send_bits(16'($urandom), 16, 1);
            if (k == 254) begin
                tick();
                checks = checks + 1;
                if (word_count !== 8'd255) begin
                    errors = errors + 1;
                    $display("FAIL count_255: got %0d expected 255", word_count);
                end
            end
        end
        tick();
        tick();
        checks = checks + 1;
        if (word_count !== 8'd0 || ovf !== 1'b0 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL count_wrap: cnt=%0d ovf=%b pending=%0d expected 0 0 0",
                     word_count, ovf, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure_ovf();
        test_reset_midword();
        test_gaps();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_deserializer
